// File: rtl/sequential_signed_divider_4.sv
// Sequential signed divider: 8-bit dividend / 4-bit divisor -> 4-bit quotient and remainder.
// Restoring division on operand magnitudes, one quotient bit per cycle, signs applied at the end.
// Fixed latency: done pulses 9 edges after start is sampled, for every operand combination.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, sampled only while idle
//   dividend, divisor   signed two's-complement operands
//   busy, done          operation in progress / one-cycle result-valid pulse
//   quotient, remainder signed results (truncation toward zero)
//   div_by_zero         last operation had divisor 0
//   overflow            last operation had a true quotient outside [-8,7]
module sequential_signed_divider_4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero,
  output logic       overflow
);

  localparam int unsigned DD_W  = 8;
  localparam int unsigned DV_W  = 4;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;

  logic [DD_W-1:0]   r_dvd;      // dividend magnitude, becomes quotient magnitude as bits shift in
  logic [DV_W-1:0]   r_dvs;      // divisor magnitude
  logic [DV_W-1:0]   r_rem;      // partial remainder
  logic              r_sdd;
  logic              r_sdv;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_busy;
  logic              r_done;
  logic [DV_W-1:0]   r_quotient;
  logic [DV_W-1:0]   r_remainder;
  logic              r_div_by_zero;
  logic              r_overflow;

  // Operand magnitudes; the extra bit keeps -128 representable as +128
  logic [DD_W:0]     w_dd_ext;
  logic [DD_W:0]     w_dd_neg;
  logic [DD_W-1:0]   w_dd_mag;
  logic [DV_W:0]     w_dv_ext;
  logic [DV_W:0]     w_dv_neg;
  logic [DV_W-1:0]   w_dv_mag;

  assign w_dd_ext = {dividend[DD_W-1], dividend};
  assign w_dd_neg = (DD_W+1)'(0) - w_dd_ext;
  assign w_dd_mag = dividend[DD_W-1] ? w_dd_neg[DD_W-1:0] : dividend;
  assign w_dv_ext = {divisor[DV_W-1], divisor};
  assign w_dv_neg = (DV_W+1)'(0) - w_dv_ext;
  assign w_dv_mag = divisor[DV_W-1] ? w_dv_neg[DV_W-1:0] : divisor;

  // One restoring step: shift in next dividend bit, subtract divisor if it fits
  logic [DV_W:0]     w_rem_sh;
  logic              w_ge;
  logic [DV_W-1:0]   w_rem_nxt;

  assign w_rem_sh  = {r_rem, r_dvd[DD_W-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? DV_W'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[DV_W-1:0];

  // Sign fix-up and range check on the final magnitudes; -8 is the only legal magnitude-8 result
  logic              w_q_neg;
  logic              w_ovf;
  logic              w_dz;
  logic [DV_W-1:0]   w_q_fix;
  logic [DV_W-1:0]   w_r_fix;

  assign w_q_neg = r_sdd ^ r_sdv;
  assign w_ovf   = w_q_neg ? (r_dvd > DD_W'(8)) : (r_dvd > DD_W'(7));
  assign w_dz    = (r_dvs == DV_W'(0));
  assign w_q_fix = w_q_neg ? DV_W'(DV_W'(0) - r_dvd[DV_W-1:0]) : r_dvd[DV_W-1:0];
  assign w_r_fix = r_sdd ? DV_W'(DV_W'(0) - r_rem) : r_rem;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (r_cnt == CNT_W'(7)) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (r_state == FIX);
  end

  // Datapath: latch in IDLE, iterate in CALC, publish results in FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd         <= '0;
      r_dvs         <= '0;
      r_rem         <= '0;
      r_sdd         <= 1'b0;
      r_sdv         <= 1'b0;
      r_cnt         <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd <= w_dd_mag;
            r_dvs <= w_dv_mag;
            r_sdd <= dividend[DD_W-1];
            r_sdv <= divisor[DV_W-1];
            r_rem <= '0;
            r_cnt <= '0;
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[DD_W-2:0], w_ge};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          if (w_dz) begin
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b1;
            r_overflow    <= 1'b0;
          end else if (w_ovf) begin
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b1;
          end else begin
            r_quotient    <= w_q_fix;
            r_remainder   <= w_r_fix;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_sequential_signed_divider_4.sv
// Directed testbench for sequential_signed_divider_4.
module tb_sequential_signed_divider_4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  int checks;
  int failures;

  sequential_signed_divider_4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge: present a start for one rising edge, return at the next negedge
  task automatic launch(input logic [7:0] dd, input logic [3:0] dv);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Counts negedges until done; bad counts cycles where busy/done disagree with protocol
  task automatic wait_done(output int lat, output int bad);
    lat = 0;
    bad = 0;
    while (done !== 1'b1 && lat < 30) begin
      if (busy !== 1'b1) bad++;
      @(negedge clk);
      lat++;
    end
    if (done === 1'b1 && busy !== 1'b0) bad++;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_busy_done got=%b exp=00", {busy, done});
    end
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== 10'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000", {quotient, remainder, div_by_zero, overflow});
    end
    rst_n = 1'b1;
  endtask

  // First start right at reset release: 21/3
  task automatic test_basic;
    int lat, bad;
    launch(8'd21, 4'd3);
    wait_done(lat, bad);
    checks++;
    if (lat !== 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL basic_busy_profile got=%0d bad cycles exp=0", bad); end
    checks++;
    if (quotient !== 4'd7 || remainder !== 4'd0) begin
      failures++; $display("FAIL basic_result got=q%h r%h exp=q7 r0", quotient, remainder);
    end
    checks++;
    if ({div_by_zero, overflow} !== 2'b00) begin
      failures++; $display("FAIL basic_flags got=%b exp=00", {div_by_zero, overflow});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || quotient !== 4'd7) begin
      failures++; $display("FAIL basic_done_pulse got=done%b q%h exp=done0 q7", done, quotient);
    end
  endtask

  // Directed vectors: dividend, divisor, quotient, remainder, div_by_zero, overflow
  task automatic test_vectors;
    logic [7:0] t_dd [17];
    logic [3:0] t_dv [17];
    logic [3:0] t_q  [17];
    logic [3:0] t_r  [17];
    logic [1:0] t_f  [17];
    int lat, bad;
    t_dd[0]  = 8'hEE; t_dv[0]  = 4'h3; t_q[0]  = 4'hA; t_r[0]  = 4'h0; t_f[0]  = 2'b00; // -18/3
    t_dd[1]  = 8'h12; t_dv[1]  = 4'hA; t_q[1]  = 4'hD; t_r[1]  = 4'h0; t_f[1]  = 2'b00; // 18/-6
    t_dd[2]  = 8'hE2; t_dv[2]  = 4'h4; t_q[2]  = 4'h9; t_r[2]  = 4'hE; t_f[2]  = 2'b00; // -30/4
    t_dd[3]  = 8'h1E; t_dv[3]  = 4'hC; t_q[3]  = 4'h9; t_r[3]  = 4'h2; t_f[3]  = 2'b00; // 30/-4
    t_dd[4]  = 8'h07; t_dv[4]  = 4'h2; t_q[4]  = 4'h3; t_r[4]  = 4'h1; t_f[4]  = 2'b00; // 7/2
    t_dd[5]  = 8'hF9; t_dv[5]  = 4'h2; t_q[5]  = 4'hD; t_r[5]  = 4'hF; t_f[5]  = 2'b00; // -7/2
    t_dd[6]  = 8'hF9; t_dv[6]  = 4'hE; t_q[6]  = 4'h3; t_r[6]  = 4'hF; t_f[6]  = 2'b00; // -7/-2
    t_dd[7]  = 8'hC0; t_dv[7]  = 4'h8; t_q[7]  = 4'h0; t_r[7]  = 4'h0; t_f[7]  = 2'b01; // -64/-8
    t_dd[8]  = 8'hC0; t_dv[8]  = 4'h7; t_q[8]  = 4'h0; t_r[8]  = 4'h0; t_f[8]  = 2'b01; // -64/7
    t_dd[9]  = 8'h38; t_dv[9]  = 4'h9; t_q[9]  = 4'h8; t_r[9]  = 4'h0; t_f[9]  = 2'b00; // 56/-7
    t_dd[10] = 8'h80; t_dv[10] = 4'hF; t_q[10] = 4'h0; t_r[10] = 4'h0; t_f[10] = 2'b01; // -128/-1
    t_dd[11] = 8'h64; t_dv[11] = 4'h3; t_q[11] = 4'h0; t_r[11] = 4'h0; t_f[11] = 2'b01; // 100/3
    t_dd[12] = 8'h05; t_dv[12] = 4'h0; t_q[12] = 4'h0; t_r[12] = 4'h0; t_f[12] = 2'b10; // 5/0
    t_dd[13] = 8'hC7; t_dv[13] = 4'h8; t_q[13] = 4'h7; t_r[13] = 4'hF; t_f[13] = 2'b00; // -57/-8
    t_dd[14] = 8'h00; t_dv[14] = 4'hB; t_q[14] = 4'h0; t_r[14] = 4'h0; t_f[14] = 2'b00; // 0/-5
    t_dd[15] = 8'h80; t_dv[15] = 4'h0; t_q[15] = 4'h0; t_r[15] = 4'h0; t_f[15] = 2'b10; // -128/0
    t_dd[16] = 8'h7F; t_dv[16] = 4'h7; t_q[16] = 4'h0; t_r[16] = 4'h0; t_f[16] = 2'b01; // 127/7
    for (int i = 0; i < 17; i++) begin
      launch(t_dd[i], t_dv[i]);
      wait_done(lat, bad);
      checks++;
      if (lat !== 9 || bad !== 0) begin
        failures++; $display("FAIL vec%0d_timing got=lat%0d bad%0d exp=lat9 bad0", i, lat, bad);
      end
      checks++;
      if (quotient !== t_q[i] || remainder !== t_r[i]) begin
        failures++;
        $display("FAIL vec%0d_result got=q%h r%h exp=q%h r%h", i, quotient, remainder, t_q[i], t_r[i]);
      end
      checks++;
      if ({div_by_zero, overflow} !== t_f[i]) begin
        failures++; $display("FAIL vec%0d_flags got=%b exp=%b", i, {div_by_zero, overflow}, t_f[i]);
      end
      @(negedge clk);
    end
  endtask

  // start re-pulsed with new operands mid-operation must have no effect
  task automatic test_ignore_start;
    int lat, bad;
    launch(8'd21, 4'd3);
    @(negedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'hE2;
    divisor  = 4'h4;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 4'h0;
    wait_done(lat, bad);
    checks++;
    if (lat + 3 !== 9 || bad !== 0) begin
      failures++; $display("FAIL ignore_timing got=lat%0d bad%0d exp=lat9 bad0", lat + 3, bad);
    end
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {4'h7, 4'h0, 2'b00}) begin
      failures++; $display("FAIL ignore_result got=q%h r%h f%b exp=q7 r0 f00",
                           quotient, remainder, {div_by_zero, overflow});
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++; $display("FAIL ignore_no_restart got=%b exp=00", {busy, done});
    end
  endtask

  // Reset mid-operation aborts asynchronously with no done pulse
  task automatic test_reset_mid;
    int seen_done;
    launch(8'hE2, 4'h4);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++; $display("FAIL rstmid_busy_done got=%b exp=00", {busy, done});
    end
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== 10'h000) begin
      failures++; $display("FAIL rstmid_outputs got=%h exp=000", {quotient, remainder, div_by_zero, overflow});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      failures++; $display("FAIL rstmid_no_done got=%0d active cycles exp=0", seen_done);
    end
  endtask

  // Second start presented in the done cycle is accepted
  task automatic test_back_to_back;
    int lat, bad;
    launch(8'd21, 4'd3);
    wait_done(lat, bad);
    checks++;
    if (lat !== 9 || quotient !== 4'd7) begin
      failures++; $display("FAIL b2b_first got=lat%0d q%h exp=lat9 q7", lat, quotient);
    end
    launch(8'hEE, 4'h3);
    wait_done(lat, bad);
    checks++;
    if (lat !== 9 || bad !== 0) begin
      failures++; $display("FAIL b2b_second_timing got=lat%0d bad%0d exp=lat9 bad0", lat, bad);
    end
    checks++;
    if (quotient !== 4'hA || remainder !== 4'h0) begin
      failures++; $display("FAIL b2b_second_result got=q%h r%h exp=qa r0", quotient, remainder);
    end
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
